pc_predict_unit: RTL and testbench

Fetch-side program-counter register and next-PC predictor for the pipelined Y86-64 processor; the successor to the single-cycle SEQ PC update. Each cycle it selects the next fetch address from the current instruction's predicted target, pipeline redirects, stalls and halt conditions. A parametrised-depth return-address stack (RAS) predicts `ret` targets. It sits between fetch (F) and the instruction memory address port, with correction inputs from memory (M) and writeback (W).

---
 rtl/pc_predict_unit.sv | 147 ++++++++++++++
 tb/tb_pc_predict_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
// ---------------------------------------------------------------------------
// pc_predict_unit
//
// Fetch-side PC register and next-PC predictor for a pipelined Y86-64 core.
// Each cycle it picks the next fetch address from, in priority order:
// halt/status hold, W ret-mispredict redirect, M branch-mispredict redirect,
// load/use stall, invalid fetch, and finally the predicted PC of the
// instruction currently being fetched. A circular return-address stack (RAS)
// predicts `ret` targets.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   f_valid           f_icode/f_valC/f_valP describe the instruction at f_pc
//   f_icode           fetched icode (0 halt, 7 jXX, 8 call, 9 ret)
//   f_valC, f_valP    destination field and fall-through address
//   stall             hold the PC (load/use hazard)
//   m_mispredict      jXX in M was wrongly predicted taken; m_valA = fix-up PC
//   w_ret_mispredict  ret in W went somewhere else; w_valM = actual target
//   status            W pipeline status; nonzero halts
//   f_pc              registered fetch address
//   halted            sticky halt flag (cleared only by reset)
//   ras_count         number of valid RAS entries
//   ras_overflow      sticky: push while RAS full
//   ras_underflow     sticky: pop while RAS empty
// ---------------------------------------------------------------------------
module pc_predict_unit #(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         f_valid,
  input  logic [3:0]                   f_icode,
  input  logic [ADDR_W-1:0]            f_valC,
  input  logic [ADDR_W-1:0]            f_valP,
  input  logic                         stall,
  input  logic                         m_mispredict,
  input  logic [ADDR_W-1:0]            m_valA,
  input  logic                         w_ret_mispredict,
  input  logic [ADDR_W-1:0]            w_valM,
  input  logic [1:0]                   status,
  output logic [ADDR_W-1:0]            f_pc,
  output logic                         halted,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] ICODE_HALT = 4'd0;
  localparam logic [3:0] ICODE_JXX  = 4'd7;
  localparam logic [3:0] ICODE_CALL = 4'd8;
  localparam logic [3:0] ICODE_RET  = 4'd9;

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              halted_reg, halted_next;
  logic [PW-1:0]     ptr_reg;          // next slot to write; top is ptr_reg-1
  logic [CW-1:0]     count_reg;
  logic              ovf_reg, unf_reg;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  logic              do_push, do_pop, unf_set;
  logic [PW-1:0]     top_idx;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty, ras_full;

  assign top_idx   = ptr_reg - PW'(1);
  assign ras_top   = ras_mem[top_idx];
  assign ras_empty = (count_reg == '0);
  assign ras_full  = (count_reg == CW'(RAS_DEPTH));

  always_comb begin
    pc_next     = pc_reg;
    halted_next = halted_reg;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    unf_set     = 1'b0;
    if (halted_reg || status != 2'd0) begin
      if (status != 2'd0) halted_next = 1'b1;
    end else if (w_ret_mispredict) begin
      pc_next = w_valM;
    end else if (m_mispredict) begin
      pc_next = m_valA;
    end else if (stall || !f_valid) begin
      pc_next = pc_reg;
    end else begin
      unique case (f_icode)
        ICODE_JXX:  pc_next = f_valC;
        ICODE_CALL: begin
          pc_next = f_valC;
          do_push = 1'b1;
        end
        ICODE_RET: begin
          if (ras_empty) begin
            pc_next = f_valP;
            unf_set = 1'b1;
          end else begin
            pc_next = ras_top;
            do_pop  = 1'b1;
          end
        end
        ICODE_HALT: halted_next = 1'b1;
        default:    pc_next = f_valP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg     <= RESET_PC;
      halted_reg <= 1'b0;
      ptr_reg    <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      halted_reg <= halted_next;
      if (unf_set) unf_reg <= 1'b1;
      if (do_push) begin
        // When full, ptr_reg already points at the oldest entry, so the
        // write below overwrites it and the count stays saturated.
        ptr_reg <= ptr_reg + PW'(1);
        if (ras_full) ovf_reg <= 1'b1;
        else          count_reg <= count_reg + CW'(1);
      end else if (do_pop) begin
        ptr_reg   <= top_idx;
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  // Contents need no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[ptr_reg] <= f_valP;
  end

  assign f_pc          = pc_reg;
  assign halted        = halted_reg;
  assign ras_count     = count_reg;
  assign ras_overflow  = ovf_reg;
  assign ras_underflow = unf_reg;

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;
  localparam int AW = 64;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic f_valid = 1'b0;
  logic [3:0] f_icode = 4'd1;
  logic [AW-1:0] f_valC = '0, f_valP = '0, m_valA = '0, w_valM = '0;
  logic stall = 1'b0, m_mispredict = 1'b0, w_ret_mispredict = 1'b0;
  logic [1:0] status = 2'd0;
  logic [AW-1:0] f_pc;
  logic halted, ras_overflow, ras_underflow;
  logic [CW-1:0] ras_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: a bounded queue of return addresses (back = top).
  logic [AW-1:0] m_pc;
  logic m_halted, m_ovf, m_unf;
  logic [AW-1:0] m_ras[$];

  pc_predict_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_icode(f_icode),
    .f_valC(f_valC), .f_valP(f_valP), .stall(stall),
    .m_mispredict(m_mispredict), .m_valA(m_valA),
    .w_ret_mispredict(w_ret_mispredict), .w_valM(w_valM), .status(status),
    .f_pc(f_pc), .halted(halted), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = '0; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_update();
    if (m_halted || status != 2'd0) begin
      if (status != 2'd0) m_halted = 1'b1;
    end else if (w_ret_mispredict) m_pc = w_valM;
    else if (m_mispredict) m_pc = m_valA;
    else if (stall || !f_valid) m_pc = m_pc;
    else begin
      case (f_icode)
        4'd7: m_pc = f_valC;
        4'd8: begin
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(f_valP);
          m_pc = f_valC;
        end
        4'd9: begin
          if (m_ras.size() == 0) begin
            m_pc = f_valP;
            m_unf = 1'b1;
          end else m_pc = m_ras.pop_back();
        end
        4'd0: m_halted = 1'b1;
        default: m_pc = f_valP;
      endcase
    end
  endtask

  task automatic idle();
    f_valid = 1'b0; f_icode = 4'd1; f_valC = '0; f_valP = '0;
    stall = 1'b0; m_mispredict = 1'b0; w_ret_mispredict = 1'b0; status = 2'd0;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [AW-1:0] vc, input logic [AW-1:0] vp);
    f_valid = 1'b1; f_icode = ic; f_valC = vc; f_valP = vp;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    $display("cycle: icode=%0d f_pc=%h cnt=%0d halted=%b ovf=%b unf=%b",
             f_icode, f_pc, ras_count, halted, ras_overflow, ras_underflow);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (f_pc !== 64'h0 || halted !== 1'b0 || ras_count !== '0 ||
        ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: pc=%h halt=%b cnt=%0d ovf=%b unf=%b required all zero",
               f_pc, halted, ras_count, ras_overflow, ras_underflow);
    end
    model_reset();
    #2 rst_n = 1'b1;
    fetch(4'd6, 64'h0, 64'h7);
    tick();
    n_cmp++;
    if (f_pc !== 64'h7) begin
      n_err++; $display("FAIL opq_step: f_pc=%h required 7", f_pc);
    end
    fetch(4'd8, 64'h40, 64'h50);
    tick();
    n_cmp++;
    if (f_pc !== 64'h40 || ras_count !== CW'(1)) begin
      n_err++; $display("FAIL pre_reset_call: f_pc=%h cnt=%0d required 40/1", f_pc, ras_count);
    end
    // Reset mid-sequence with a pending call on the inputs.
    fetch(4'd8, 64'h80, 64'h90);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (f_pc !== 64'h0 || ras_count !== '0) begin
      n_err++; $display("FAIL async_reset: f_pc=%h cnt=%0d required 0/0", f_pc, ras_count);
    end
    model_reset();
    idle();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_call_ret();
    fetch(4'd8, 64'h40, 64'h9);
    tick();
    n_cmp++;
    if (f_pc !== 64'h40 || ras_count !== CW'(1)) begin
      n_err++; $display("FAIL call: f_pc=%h cnt=%0d required 40/1", f_pc, ras_count);
    end
    fetch(4'd9, 64'h0, 64'h41);
    tick();
    n_cmp++;
    if (f_pc !== 64'h9 || ras_count !== '0) begin
      n_err++; $display("FAIL ret: f_pc=%h cnt=%0d required 9/0", f_pc, ras_count);
    end
  endtask

  task automatic test_redirect();
    fetch(4'd7, 64'h107, 64'h9);
    tick();
    n_cmp++;
    if (f_pc !== 64'h107) begin
      n_err++; $display("FAIL jxx: f_pc=%h required 107", f_pc);
    end
    fetch(4'd6, 64'h0, 64'h110);
    m_mispredict = 1'b1; m_valA = 64'h9; stall = 1'b1;
    tick();
    n_cmp++;
    if (f_pc !== 64'h9) begin
      n_err++; $display("FAIL redirect_over_stall: f_pc=%h required 9", f_pc);
    end
    // Both redirects plus a valid call that must not push.
    fetch(4'd8, 64'h500, 64'h600);
    stall = 1'b0;
    w_ret_mispredict = 1'b1; w_valM = 64'h200; m_mispredict = 1'b1; m_valA = 64'h300;
    tick();
    n_cmp++;
    if (f_pc !== 64'h200 || ras_count !== '0) begin
      n_err++; $display("FAIL w_over_m: f_pc=%h cnt=%0d required 200/0", f_pc, ras_count);
    end
    idle();
  endtask

  task automatic test_ras_overflow();
    for (int i = 0; i < 9; i++) begin
      fetch(4'd8, 64'h1000, 64'h10 + 64'(i));
      tick();
    end
    n_cmp++;
    if (ras_overflow !== 1'b1 || ras_count !== CW'(8) || ras_underflow !== 1'b0) begin
      n_err++; $display("FAIL overflow: ovf=%b cnt=%0d unf=%b required 1/8/0",
                        ras_overflow, ras_count, ras_underflow);
    end
    for (int i = 0; i < 8; i++) begin
      fetch(4'd9, 64'h0, 64'h2000);
      tick();
      n_cmp++;
      if (f_pc !== 64'h18 - 64'(i)) begin
        n_err++; $display("FAIL ras_pop%0d: f_pc=%h required %h", i, f_pc, 64'h18 - 64'(i));
      end
    end
    fetch(4'd9, 64'h0, 64'h77);
    tick();
    n_cmp++;
    if (f_pc !== 64'h77 || ras_underflow !== 1'b1 || ras_count !== '0) begin
      n_err++; $display("FAIL underflow: f_pc=%h unf=%b cnt=%0d required 77/1/0",
                        f_pc, ras_underflow, ras_count);
    end
    idle();
  endtask

  task automatic test_halt();
    logic [AW-1:0] held;
    fetch(4'd6, 64'h0, 64'h123);
    tick();
    held = f_pc;
    fetch(4'd8, 64'h500, 64'h600);
    status = 2'd2;
    tick();
    n_cmp++;
    if (halted !== 1'b1 || f_pc !== 64'h123) begin
      n_err++; $display("FAIL status_halt: halted=%b f_pc=%h required 1/123", halted, f_pc);
    end
    status = 2'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (f_pc !== held || ras_count !== '0 || halted !== 1'b1) begin
        n_err++; $display("FAIL halt_frozen%0d: f_pc=%h cnt=%0d halted=%b required %h/0/1",
                          i, f_pc, ras_count, halted, held);
      end
    end
    do_reset();
    fetch(4'd6, 64'h0, 64'h20);
    tick();
    fetch(4'd0, 64'h0, 64'h21);
    tick();
    n_cmp++;
    if (halted !== 1'b1 || f_pc !== 64'h20) begin
      n_err++; $display("FAIL icode_halt: halted=%b f_pc=%h required 1/20", halted, f_pc);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [3:0] ics [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8,
                             4'd9, 4'd9, 4'd10, 4'd11};
    for (int c = 0; c < 400; c++) begin
      fetch(ics[$urandom_range(0, 12)], {$urandom, $urandom}, {$urandom, $urandom});
      f_valid = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 7) == 0);
      m_mispredict = ($urandom_range(0, 11) == 0);
      m_valA = {$urandom, $urandom};
      w_ret_mispredict = ($urandom_range(0, 15) == 0);
      w_valM = {$urandom, $urandom};
      tick();
      n_cmp++;
      if (f_pc !== m_pc || ras_count !== CW'(m_ras.size()) || halted !== m_halted ||
          ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
        n_err++;
        $display("FAIL random%0d: pc=%h cnt=%0d h=%b o=%b u=%b required pc=%h cnt=%0d h=%b o=%b u=%b",
                 c, f_pc, ras_count, halted, ras_overflow, ras_underflow,
                 m_pc, m_ras.size(), m_halted, m_ovf, m_unf);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_call_ret();
    test_redirect();
    test_ras_overflow();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
